// File: rtl/mux_scan_sequencer.sv
// Four-channel scan controller for a 4:1 mux: drives S/En, settles, samples y_in per channel.
// Optional `SCAN_AUTO_REPEAT_EN`: a start seen in DONE chains straight into the next scan.
module mux_scan_sequencer #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic [1:0] S,
    output logic       En,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample
);

    // A dwell of 0 would skip settling entirely, so clamp it to 1.
    localparam int unsigned DwellEff = (DWELL == 0) ? 1 : DWELL;
    localparam logic [7:0]  CntLoad  = 8'(DwellEff - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] shadow_q, shadow_d;
    logic [1:0] s_q, s_d;
    logic       en_q, en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] sample_q, sample_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        s_d      = s_q;
        en_d     = en_q;
        sample_d = sample_q;
        unique case (state_q)
            StIdle: begin
                en_d = 1'b1;
                s_d  = 2'd0;
                if (start) begin
                    state_d = StSettle;
                    en_d    = 1'b0;
                    cnt_d   = CntLoad;
                end
            end
            StSettle: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (s_q != 2'd3) begin
                    shadow_d[s_q] = y_in;
                    s_d           = s_q + 2'd1;
                    cnt_d         = CntLoad;
                    state_d       = StSettle;
                end else begin
                    sample_d = {y_in, shadow_q};
                    en_d     = 1'b1;
                    s_d      = 2'd0;
                    state_d  = StDone;
                end
            end
            StDone: begin
`ifdef SCAN_AUTO_REPEAT_EN
                if (start) begin
                    state_d = StSettle;
                    s_d     = 2'd0;
                    en_d    = 1'b0;
                    cnt_d   = CntLoad;
                end else begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
        // Status flags are registered from the next state so they line up with it.
        busy_d = (state_d == StSettle) || (state_d == StSample);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            shadow_q <= 3'd0;
            s_q      <= 2'd0;
            en_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            s_q      <= s_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sample_q <= sample_d;
        end
    end

    assign S      = s_q;
    assign En     = en_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign sample = sample_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: DWELL=2, 1 and 0 instances, each with a mux model.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start2 = 1'b0, start1 = 1'b0, start0 = 1'b0;
    logic [3:0] i2 = 4'b0, i1 = 4'b0, i0 = 4'b0;
    logic       y2, y1, y0;
    logic [1:0] s2, s1, s0;
    logic       en2, en1, en0, busy2, busy1, busy0, done2, done1, done0;
    logic [3:0] smp2, smp1, smp0;

    mux_scan_sequencer #(.DWELL(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .y_in(y2),
        .S(s2), .En(en2), .busy(busy2), .done(done2), .sample(smp2)
    );
    mux_scan_sequencer #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y_in(y1),
        .S(s1), .En(en1), .busy(busy1), .done(done1), .sample(smp1)
    );
    mux_scan_sequencer #(.DWELL(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .y_in(y0),
        .S(s0), .En(en0), .busy(busy0), .done(done0), .sample(smp0)
    );

    // Mux model: active-low enable, y forced to 0 when disabled.
    assign y2 = en2 ? 1'b0 : i2[s2];
    assign y1 = en1 ? 1'b0 : i1[s1];
    assign y0 = en0 ? 1'b0 : i0[s0];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       start;
        logic [1:0] s;
        logic       en;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vec[14];

    initial begin
        int dc;
        int k;
        int s1_hist[10];
        int d1_at, d0_at;

        // Entry i: start driven before edge E0+i, expected outputs after that edge.
        // start pulses at 4 and 8 (busy) and 12 (SAMPLE of ch3) must all be ignored.
        vec[0]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
        vec[1]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vec[2]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vec[3]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
        vec[4]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0};
        vec[5]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
        vec[6]  = '{1'b0, 2'd2, 1'b0, 1'b1, 1'b0};
        vec[7]  = '{1'b0, 2'd2, 1'b0, 1'b1, 1'b0};
        vec[8]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
        vec[9]  = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0};
        vec[10] = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0};
        vec[11] = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0};
        vec[12] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1};
        vec[13] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0};

        // Reset held two cycles with start high: nothing may start.
        rst = 1'b1;
        start2 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_S", s2, 0);
            check("rst_En", en2, 1);
            check("rst_busy", busy2, 0);
            check("rst_done", done2, 0);
            check("rst_sample", smp2, 0);
        end
        start2 = 1'b0;
        rst = 1'b0;
        step();
        check("post_rst_busy", busy2, 0);

        // Single scan, DWELL=2, I=1010, with ignored start pulses.
        i2 = 4'b1010;
        dc = 0;
        for (int i = 0; i < 14; i++) begin
            start2 = vec[i].start;
            step();
            start2 = 1'b0;
            if (done2) dc++;
            check($sformatf("scan_S[%0d]", i), s2, vec[i].s);
            check($sformatf("scan_En[%0d]", i), en2, vec[i].en);
            check($sformatf("scan_busy[%0d]", i), busy2, vec[i].busy);
            check($sformatf("scan_done[%0d]", i), done2, vec[i].done);
        end
        check("scan_sample", smp2, 4'b1010);
        for (int c = 0; c < 3; c++) begin
            step();
            if (done2) dc++;
        end
        check("scan_done_count", dc, 1);
        check("scan_idle_En", en2, 1);

        // DWELL=1 (I=0110) and DWELL=0 (I=0110) started together.
        i1 = 4'b0110;
        i0 = 4'b0110;
        start1 = 1'b1;
        start0 = 1'b1;
        step();
        start1 = 1'b0;
        start0 = 1'b0;
        d1_at = -1;
        d0_at = -1;
        s1_hist[0] = s1;
        for (int e = 1; e < 10; e++) begin
            step();
            s1_hist[e] = s1;
            if (done1 && d1_at < 0) d1_at = e;
            if (done0 && d0_at < 0) d0_at = e;
        end
        check("d1_S_at1", s1_hist[1], 0);
        check("d1_S_at2", s1_hist[2], 1);
        check("d1_S_at4", s1_hist[4], 2);
        check("d1_S_at7", s1_hist[7], 3);
        check("d1_done_edge", d1_at, 8);
        check("d0_done_edge", d0_at, 8);
        check("d1_sample", smp1, 4'b0110);
        check("d0_sample", smp0, 4'b0110);

        // Reset at the SAMPLE cycle with S=2 (state after edge E0+8).
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int e = 1; e <= 8; e++) step();
        check("mid_pre_S", s2, 2);
        check("mid_pre_sample", smp2, 4'b1010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_En", en2, 1);
        check("mid_S", s2, 0);
        check("mid_sample", smp2, 0);
        check("mid_busy", busy2, 0);
        dc = 0;
        if (done2) dc++;
        for (int c = 0; c < 15; c++) begin
            step();
            if (done2) dc++;
        end
        check("mid_no_done", dc, 0);
        check("mid_sample_hold", smp2, 0);

        // start held high across two scans; I changes after the first done.
        i2 = 4'b1111;
        start2 = 1'b1;
        k = 0;
        d1_at = -1;
        while (!done2 && k < 40) begin
            step();
            k++;
        end
        check("rep_first_done_seen", done2, 1);
        check("rep_first_sample", smp2, 4'b1111);
        i2 = 4'b0001;
        k = 0;
        do begin
            step();
            k++;
            if (k == 1) check("rep_done_one_cycle", done2, 0);
        end while (!done2 && k < 40);
`ifdef SCAN_AUTO_REPEAT_EN
        check("rep_period", k, 13);
`else
        check("rep_period", k, 14);
`endif
        check("rep_second_sample", smp2, 4'b0001);
        start2 = 1'b0;
        for (int c = 0; c < 16; c++) step();
        check("rep_final_idle", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
